fir_mac: RTL and testbench
==========================

# fir_mac

Parametrised single-multiplier FIR filter. It is the next-generation replacement for the fixed `fir` block in the audio sample path. Each sample arrives on a strobe at the sample rate, and the block time-multiplexes one multiply-accumulate over TAPS cycles of the system clock. It adds two things the fixed block lacks: runtime-programmable coefficients through a shadow/active register bank, and overrun detection.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `COEF_W`, 16: coefficient width, signed, Q1.(COEF_W-1) format.
- `TAPS`, 8: filter length, valid range 2..64.
- `ck` input 1: system clock, rising edge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `in` input DATA_W: input sample, signed.
- `input_ready` input 1: sample strobe. A sample is taken on the strobe's rising edge; the strobe may stay high for more than one cycle.
- `coef_we` input 1: coefficient shadow write enable.
- `coef_addr` input $clog2(TAPS): coefficient index.
- `coef_data` input COEF_W: coefficient value, signed.
- `out` output DATA_W: filtered sample, signed. Held between updates.
- `output_ready` output 1: one-cycle pulse when `out` updates.
- `busy` output 1: high while a MAC sequence is running.
- `overrun` output 1: sticky flag; set when a strobe edge arrives while busy.

## Operation
- State machine `IDLE -> MAC -> OUT -> IDLE`.
- **Accept:** in IDLE, when `input_ready`=1 and its registered previous value = 0:
  - shift `in` into delay line position x[0]; older samples move x[i] -> x[i+1]; x[TAPS-1] is discarded;
  - copy the shadow coefficients to the active bank;
  - clear the accumulator, set index = 0, go to MAC.
- **MAC:** each cycle, acc += x[idx] * c_active[idx]. Exit when idx = TAPS-1; stay in MAC for exactly TAPS cycles.
- **OUT:** register `out` from the scaled accumulator, pulse `output_ready`, return to IDLE.
- **Accumulator:** ACC_W = DATA_W + COEF_W + $clog2(TAPS) bits, signed. No internal overflow is possible.
- **Scaling:** result = acc >>> (COEF_W-1), arithmetic shift, truncation toward −inf. Narrowing to DATA_W is set by the configuration macro.
- **Coefficient writes** go only to the shadow bank and are accepted in any state. The active bank changes only at accept, so a write during MAC affects the next sample, never the current one. A write in the same cycle as accept is *not* included in that copy.
- **Strobe edge while busy (MAC/OUT):** the sample is dropped, `overrun` is set, and the delay line is unchanged. Only `rst` clears `overrun`. An edge in the OUT cycle also counts as busy.
- **Reset mid-operation:** the sequence is abandoned and no `output_ready` is produced.
- **Reset values:**
  - `out`=0, `output_ready`=0, `busy`=0, `overrun`=0;
  - delay line all 0, shadow and active coefficients all 0;
  - state IDLE, edge-detect register = 1, so a strobe already high at reset release is not taken.

## Timing
- Accept at clock edge k: `busy`=1 from k+1 through k+TAPS+1.
- `out` and `output_ready` are valid after edge k+TAPS+1; `output_ready` is low again after k+TAPS+2.
- Total latency from strobe edge to result is TAPS+1 cycles. The earliest next accept is edge k+TAPS+2.
- Minimum strobe period is TAPS+2 clocks. At a 1 MHz clock and 40 kHz strobe, TAPS ≤ 23 is overrun-free.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `FIR_MAC_SATURATE_EN` defined: the scaled result is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- `FIR_MAC_SATURATE_EN` undefined: the scaled result is truncated to its low DATA_W bits (wraps).

## Structure
- Package `fir_mac_pkg` holds:
  - the state enum `fir_state_t` {IDLE, MAC, OUT};
  - function `acc_width(DATA_W, COEF_W, TAPS)`;
  - function `sat_narrow` used by the saturate path.
- Sub-module `fir_coef_bank` holds the shadow and active register arrays, the write port, the copy strobe, and the read mux indexed by `idx`.
- The top level holds the edge detect, delay line, FSM, index counter, multiplier/accumulator and output stage.

## Test plan
All scenarios use TAPS=8, DATA_W=16, COEF_W=16 and a strobe every 25 clocks.
1. **Reset:** assert `rst` 2 cycles with `input_ready` held high -> `out`=0, `output_ready`=0, `busy`=0, `overrun`=0. No accept until the strobe falls and rises again.
2. **Single tap:** write c[0]=16384 (0.5), others 0; `in`=10000 -> `out`=5000, `output_ready` pulse exactly 9 cycles after the accept edge. `in`=−10000 -> `out`=−5000.
3. **Moving average:** write all c[i]=4096; apply step `in`=10000 for 8 samples from zero history -> outputs 1250, 2500, 3750, 5000, 6250, 7500, 8750, 10000, then steady 10000.
4. **Saturation:** all c[i]=32767; `in`=30000 for 2 samples. Second output: with the macro `out`=32767; without it, `out` = low 16 bits of 59998 = −5538.
5. **Overrun:** a second strobe edge 3 cycles after accept -> `overrun`=1 and stays 1. The current output uses only the first sample, and the next accepted sample shows the delay line advanced by one, not two.
6. **Coefficient write during MAC:** with c[0]=16384, write c[0]=8192 at MAC cycle 4, `in`=10000 -> current `out`=5000; next sample `in`=10000 with other taps 0 -> `out`=2500.

Source files
------------

// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared types and helpers for the fir_mac filter.
// Holds the FSM state enum, the accumulator width rule and the
// saturating narrow used when FIR_MAC_SATURATE_EN is defined.
package fir_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    // Wide enough for any accumulator the legal parameter range can produce.
    localparam int SAT_W = 128;

    // Accumulator width that makes internal overflow impossible.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a signed value to the signed range of a data_w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] v,
                                                           input int data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow/active coefficient registers for fir_mac.
// Writes land in the shadow bank at any time; the active bank is loaded
// from the shadow bank only on the copy strobe, and the MAC reads the
// active bank through an index mux.
module fir_coef_bank
    import fir_mac_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int IDX_W  = $clog2(TAPS)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [COEF_W-1:0] data,
    input  logic              copy,
    input  logic [IDX_W-1:0]  idx,
    output logic [COEF_W-1:0] coef
);

    logic [COEF_W-1:0] shadow [TAPS];
    logic [COEF_W-1:0] active [TAPS];

    // Shadow write port and shadow-to-active copy.
    always_ff @(posedge ck) begin
        if (rst) begin
            // NOTE: these small register arrays are reset on purpose because
            // an all-zero coefficient set is an observable reset state; large
            // RAM-style memories would normally be left unreset.
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (we && (int'(addr) < TAPS)) begin
                shadow[addr] <= data;
            end
            // NOTE: non-blocking assignment means the copy sees the shadow
            // value from before this cycle's write, so a same-cycle write
            // is deliberately excluded from the copy.
            if (copy) begin
                active <= shadow;
            end
        end
    end

    // Active-bank read mux for the current MAC index.
    assign coef = active[idx];

endmodule

// File: rtl/fir_mac.sv
// fir_mac: single-multiplier time-multiplexed FIR filter.
// One sample per strobe rising edge; TAPS MAC cycles then one output cycle.
// Build option: define FIR_MAC_SATURATE_EN to clamp the scaled result to
// the DATA_W signed range; otherwise the result wraps to its low DATA_W bits.
module fir_mac
    import fir_mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in,
    input  logic                     input_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic [DATA_W-1:0]        out,
    output logic                     output_ready,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    fir_state_t               state;
    fir_state_t               state_nxt;
    logic                     strobe_q;
    logic                     strobe_edge;
    logic                     accept;
    logic [DATA_W-1:0]        x [TAPS];
    logic [IDX_W-1:0]         idx;
    logic [COEF_W-1:0]        coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic [DATA_W-1:0]        result;

    assign strobe_edge = input_ready & ~strobe_q;
    assign accept      = (state == IDLE) && strobe_edge;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .IDX_W  (IDX_W)
    ) u_coef_bank (
        .ck   (ck),
        .rst  (rst),
        .we   (coef_we),
        .addr (coef_addr),
        .data (coef_data),
        .copy (accept),
        .idx  (idx),
        .coef (coef)
    );

    // Strobe edge detector; reset high so a strobe held through reset is ignored.
    always_ff @(posedge ck) begin
        if (rst) begin
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= input_ready;
        end
    end

    // State register.
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            IDLE:    if (strobe_edge) state_nxt = MAC;
            MAC:     if (idx == LAST_IDX) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line: shifts only on an accepted sample, so dropped samples leave it intact.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else if (accept) begin
            x[0] <= in;
            for (int i = 1; i < TAPS; i++) begin
                x[i] <= x[i-1];
            end
        end
    end

    assign prod = $signed(x[idx]) * $signed(coef);

    // Index counter and accumulator.
    always_ff @(posedge ck) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            idx <= '0;
            acc <= '0;
        end else if (state == MAC) begin
            idx <= idx + 1'b1;
            acc <= acc + ACC_W'(prod);
        end
    end

    assign scaled = acc >>> (COEF_W - 1);

`ifdef FIR_MAC_SATURATE_EN
    assign result = DATA_W'(sat_narrow(SAT_W'(scaled), DATA_W));
`else
    assign result = DATA_W'(scaled);
`endif

    // Registered outputs: result, ready pulse, busy and sticky overrun.
    always_ff @(posedge ck) begin
        if (rst) begin
            out          <= '0;
            output_ready <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            output_ready <= (state == OUT);
            busy         <= (state_nxt != IDLE);
            if (state == OUT) begin
                out <= result;
            end
            if (strobe_edge && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: self-checking bench for fir_mac (TAPS=8, 16-bit data/coefs).
// A sample-level model computes each result as a dot product of the sample
// history with the coefficient snapshot taken at accept, and tracks the
// busy window from the accept edge; a negedge process compares every cycle.
module tb_fir_mac;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 8;
    localparam int PERIOD = 25;
    localparam longint MAXV = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic                     ck = 1'b0;
    logic                     rst;
    logic [DATA_W-1:0]        in;
    logic                     input_ready;
    logic                     coef_we;
    logic [$clog2(TAPS)-1:0]  coef_addr;
    logic [COEF_W-1:0]        coef_data;
    logic [DATA_W-1:0]        out;
    logic                     output_ready;
    logic                     busy;
    logic                     overrun;

    int checks   = 0;
    int failures = 0;

    fir_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
        .ck           (ck),
        .rst          (rst),
        .in           (in),
        .input_ready  (input_ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .out          (out),
        .output_ready (output_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint narrow(input longint v);
`ifdef FIR_MAC_SATURATE_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        logic [DATA_W-1:0] t;
        t = DATA_W'(v);
        return longint'($signed(t));
`endif
    endfunction

    // ---------------- behavioural model ----------------
    longint hist   [TAPS];
    longint shadow [TAPS];
    longint m_out, m_pending, sum;
    bit     m_prev, m_ordy, m_busy, m_ovr, e_seen;
    int     m_left;
    bit     started = 0;

    always @(posedge ck) begin
        started = 1;
        if (rst) begin
            m_prev = 1; m_left = 0; m_ordy = 0; m_busy = 0; m_ovr = 0; m_out = 0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] = 0;
                shadow[i] = 0;
            end
        end else begin
            e_seen = input_ready && !m_prev;
            m_prev = input_ready;
            m_ordy = 0;
            if (m_left > 0) begin
                if (e_seen) m_ovr = 1;
                m_left--;
                if (m_left == 0) begin
                    m_out  = m_pending;
                    m_ordy = 1;
                end
            end else if (e_seen) begin
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = longint'($signed(in));
                sum = 0;
                for (int i = 0; i < TAPS; i++) sum += hist[i] * shadow[i];
                m_pending = narrow(sum >>> (COEF_W - 1));
                m_left = TAPS + 1;
            end
            if (coef_we) shadow[coef_addr] = longint'($signed(coef_data));
            m_busy = (m_left > 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge ck) begin
        if (started) begin
            check("out",          longint'($signed(out)), m_out);
            check("output_ready", longint'(output_ready), longint'(m_ordy));
            check("busy",         longint'(busy),         longint'(m_busy));
            check("overrun",      longint'(overrun),      longint'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input int n);
        @(negedge ck);
        rst = 1'b1;
        repeat (n) @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge ck);
        coef_we   = 1'b1;
        coef_addr = $bits(coef_addr)'(a);
        coef_data = COEF_W'(d);
        @(negedge ck);
        coef_we = 1'b0;
    endtask

    task automatic write_all(input int d);
        for (int i = 0; i < TAPS; i++) write_coef(i, d);
    endtask

    // One strobe with optional coefficient write at negedge wr_at (0 = with the
    // strobe, -1 = none) and optional second strobe edge s2_at cycles later.
    task automatic send(input int val, input int exp_v, input string name,
                        input int wr_at = -1, input int wa = 0, input int wd = 0,
                        input int s2_at = -1, input int s2_val = 0);
        int n;
        bit got;
        int drop_at;
        drop_at = (s2_at > 0) ? 1 : 2;
        @(negedge ck);
        in = DATA_W'(val);
        input_ready = 1'b1;
        if (wr_at == 0) begin
            coef_we = 1'b1; coef_addr = $bits(coef_addr)'(wa); coef_data = COEF_W'(wd);
        end
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge ck);
            n++;
            if (wr_at >= 0 && n == wr_at + 1) coef_we = 1'b0;
            if (wr_at > 0 && n == wr_at) begin
                coef_we = 1'b1; coef_addr = $bits(coef_addr)'(wa); coef_data = COEF_W'(wd);
            end
            if (n == drop_at) input_ready = 1'b0;
            if (s2_at > 0 && n == s2_at) begin
                in = DATA_W'(s2_val);
                input_ready = 1'b1;
            end
            if (s2_at > 0 && n == s2_at + 2) input_ready = 1'b0;
            if (output_ready) got = 1;
        end
        if (!got) begin
            check({name, " timeout"}, 0, 1);
        end else begin
            check({name, " latency"}, longint'(n - 1), longint'(TAPS + 1));
            check({name, " out"}, longint'($signed(out)), longint'(exp_v));
        end
        if (n < PERIOD) repeat (PERIOD - n) @(negedge ck);
    endtask

    initial begin
        int seen;
        rst = 1'b1; input_ready = 1'b1; in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // 1. reset with strobe held high: no accept until it falls and rises
        repeat (2) @(negedge ck);
        rst = 1'b0;
        repeat (4) @(negedge ck);
        check("rst out", longint'($signed(out)), 0);
        check("rst output_ready", longint'(output_ready), 0);
        check("rst busy", longint'(busy), 0);
        check("rst overrun", longint'(overrun), 0);
        input_ready = 1'b0;

        // 2. single tap 0.5
        write_coef(0, 16384);
        send(10000, 5000, "single pos");
        send(-10000, -5000, "single neg");

        // 3. moving average step response
        do_reset(1);
        write_all(4096);
        for (int i = 1; i <= 10; i++) send(10000, ((i < TAPS) ? i : TAPS) * 1250, "avg");

        // reset mid-operation: no output_ready may follow
        @(negedge ck);
        in = DATA_W'(1234); input_ready = 1'b1;
        repeat (4) @(negedge ck);
        input_ready = 1'b0;
        do_reset(1);
        seen = 0;
        repeat (15) begin
            @(negedge ck);
            if (output_ready) seen++;
        end
        check("abort no ready", longint'(seen), 0);
        check("abort busy", longint'(busy), 0);

        // 4. saturation / wrap
        write_all(32767);
        send(30000, 29999, "sat first");
`ifdef FIR_MAC_SATURATE_EN
        send(30000, 32767, "sat second");
`else
        send(30000, -5538, "wrap second");
`endif

        // 5. overrun: second edge 3 cycles after accept is dropped
        do_reset(1);
        write_coef(0, 16384);
        write_coef(1, 16384);
        send(10000, 5000, "ovr current", -1, 0, 0, 3, 20000);
        check("ovr set", longint'(overrun), 1);
        send(2000, 6000, "ovr next");
        check("ovr sticky", longint'(overrun), 1);

        // 6. coefficient write during MAC and in the accept cycle
        do_reset(1);
        write_coef(0, 16384);
        send(10000, 5000, "wr mac current", 4, 0, 8192);
        send(10000, 2500, "wr mac next");
        send(10000, 2500, "wr accept current", 0, 0, 16384);
        send(10000, 5000, "wr accept next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
